// File: rtl/caliptra_prim_edn_req_arb.sv
// Round-robin sharing of one 32-bit EDN endpoint among NumCh consumers, packing OutWidth-bit outputs.
// Defining CALIPTRA_EDN_REQ_ARB_PREFETCH_EN adds a one-output prefetch buffer filled while idle.

package caliptra_prim_edn_req_arb_pkg;

   typedef struct packed {
      logic edn_req;
   } edn_req_t;

   typedef struct packed {
      logic        edn_ack;
      logic        edn_fips;
      logic [31:0] edn_bus;
   } edn_rsp_t;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StFill    = 2'd1,
      StDeliver = 2'd2
   } arb_state_e;

endpackage

// Handshakes: a channel raises req_i and holds it until its one-cycle ack_o, which marks
// data_o/fips_o/err_o valid; an EDN word is taken in every cycle where edn_req and edn_ack are both high.
module caliptra_prim_edn_req_arb
   import caliptra_prim_edn_req_arb_pkg::*;
#(
   parameter int unsigned NumCh         = 2,
   parameter int unsigned OutWidth      = 128,
   parameter bit          RepCheck      = 1'b1,
   parameter int unsigned TimeoutCycles = 0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumCh-1:0]    req_i,
   output logic [NumCh-1:0]    ack_o,
   output logic [OutWidth-1:0] data_o,
   output logic                fips_o,
   output logic                err_o,
   output logic                timeout_o,
   output edn_req_t            edn_o,
   input  edn_rsp_t            edn_i,
   output arb_state_e          state_o
);

   localparam int unsigned WordsPerOut = OutWidth / 32;
   localparam int unsigned CntW        = (WordsPerOut > 1) ? $clog2(WordsPerOut) : 1;
   localparam int unsigned IdxW        = (NumCh > 1) ? $clog2(NumCh) : 1;
   localparam int unsigned TcW         = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WordsPerOut - 1);

   if ((OutWidth % 32) != 0 || OutWidth < 32 || NumCh == 0 || NumCh > 8) begin : g_param_err
      $error("caliptra_prim_edn_req_arb: OutWidth must be a multiple of 32 and NumCh in 1..8");
   end

   arb_state_e          state_q, state_d;
   logic [IdxW-1:0]     grant_q, rr_q, winner;
   logic                assigned_q, any_req;
   logic                take_grant, enter_fill;
   logic [CntW-1:0]     cnt_q;
   logic [OutWidth-1:0] fill_q, fill_d, data_q;
   logic                fips_acc_q, err_acc_q, fips_d, err_d;
   logic [31:0]         last_word_q;
   logic                rep_armed_q, rep_hit;
   logic                word_ack, last_word, deliver_ok;
   logic                fips_q, err_q;

`ifdef CALIPTRA_EDN_REQ_ARB_PREFETCH_EN
   logic [OutWidth-1:0] buf_q;
   logic                buf_fips_q, buf_err_q, buf_full_q, from_buf;
`endif

   // First requesting channel strictly after the last granted one, wrapping around.
   always_comb begin : rr_pick
      int unsigned c;
      winner  = '0;
      any_req = 1'b0;
      c       = 0;
      for (int unsigned i = 1; i <= NumCh; i++) begin
         c = (32'(rr_q) + i) % NumCh;
         if (!any_req && req_i[c[IdxW-1:0]]) begin
            any_req = 1'b1;
            winner  = c[IdxW-1:0];
         end
      end
   end

   assign word_ack   = (state_q == StFill) && edn_i.edn_ack;
   assign last_word  = word_ack && (cnt_q == LastCnt);
   assign deliver_ok = assigned_q && req_i[grant_q];
   assign rep_hit    = RepCheck && rep_armed_q && (edn_i.edn_bus == last_word_q);
   assign fips_d     = fips_acc_q & edn_i.edn_fips;
   assign err_d      = err_acc_q | rep_hit;

   always_comb begin
      fill_d = fill_q;
      if (word_ack) fill_d[{cnt_q, 5'b0} +: 32] = edn_i.edn_bus;
   end

   always_comb begin
      state_d    = state_q;
      take_grant = 1'b0;
      enter_fill = 1'b0;
`ifdef CALIPTRA_EDN_REQ_ARB_PREFETCH_EN
      from_buf   = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef CALIPTRA_EDN_REQ_ARB_PREFETCH_EN
            if (any_req && buf_full_q) begin
               state_d    = StDeliver;
               take_grant = 1'b1;
               from_buf   = 1'b1;
            end else if (any_req || !buf_full_q) begin
               state_d    = StFill;
               take_grant = any_req;
               enter_fill = 1'b1;
            end
`else
            if (any_req) begin
               state_d    = StFill;
               take_grant = 1'b1;
               enter_fill = 1'b1;
            end
`endif
         end
         StFill: begin
            if (last_word) state_d = deliver_ok ? StDeliver : StIdle;
         end
         StDeliver: begin
`ifdef CALIPTRA_EDN_REQ_ARB_PREFETCH_EN
            // Buffer is always empty after a delivery: start refilling it straight away.
            state_d    = StFill;
            enter_fill = 1'b1;
`else
            state_d    = StIdle;
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         rr_q        <= '0;
         assigned_q  <= 1'b0;
         cnt_q       <= '0;
         fill_q      <= '0;
         fips_acc_q  <= 1'b1;
         err_acc_q   <= 1'b0;
         last_word_q <= '0;
         rep_armed_q <= 1'b0;
         data_q      <= '0;
         fips_q      <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (take_grant) begin
            grant_q    <= winner;
            assigned_q <= 1'b1;
         end else if (enter_fill) begin
            assigned_q <= 1'b0;
         end else if (state_q == StFill && !req_i[grant_q]) begin
            assigned_q <= 1'b0;
         end
         if (enter_fill) begin
            cnt_q      <= '0;
            fips_acc_q <= 1'b1;
            err_acc_q  <= 1'b0;
         end else if (word_ack) begin
            cnt_q      <= cnt_q + 1'b1;
            fips_acc_q <= fips_d;
            err_acc_q  <= err_d;
            fill_q     <= fill_d;
         end
         if (word_ack) begin
            last_word_q <= edn_i.edn_bus;
            rep_armed_q <= 1'b1;
         end
         if (last_word && deliver_ok) begin
            data_q <= fill_d;
            fips_q <= fips_d;
            err_q  <= err_d;
         end
`ifdef CALIPTRA_EDN_REQ_ARB_PREFETCH_EN
         else if (from_buf) begin
            data_q <= buf_q;
            fips_q <= buf_fips_q;
            err_q  <= buf_err_q;
         end
`endif
         if (state_q == StDeliver) rr_q <= grant_q;
      end
   end

`ifdef CALIPTRA_EDN_REQ_ARB_PREFETCH_EN
   // Unassigned fills and fills whose requester went away both land here.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_q      <= '0;
         buf_fips_q <= 1'b1;
         buf_err_q  <= 1'b0;
         buf_full_q <= 1'b0;
      end else if (last_word && !deliver_ok) begin
         buf_q      <= fill_d;
         buf_fips_q <= fips_d;
         buf_err_q  <= err_d;
         buf_full_q <= 1'b1;
      end else if (from_buf) begin
         buf_full_q <= 1'b0;
      end
   end
`endif

   if (TimeoutCycles > 0) begin : g_timeout
      logic [TcW-1:0] tcnt_q;
      logic           timeout_q;
      // Counter saturates at TimeoutCycles, so the pulse fires once per stall.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
         end else begin
            if (enter_fill || word_ack) begin
               tcnt_q <= '0;
            end else if (state_q == StFill && tcnt_q != TcW'(TimeoutCycles)) begin
               tcnt_q <= tcnt_q + 1'b1;
            end
            timeout_q <= (state_q == StFill) && !word_ack && (tcnt_q == TcW'(TimeoutCycles - 1));
         end
      end
      assign timeout_o = timeout_q;
   end else begin : g_no_timeout
      assign timeout_o = 1'b0;
   end

   always_comb begin
      ack_o = '0;
      if (state_q == StDeliver && assigned_q) ack_o[grant_q] = req_i[grant_q];
   end

   assign data_o        = data_q;
   assign fips_o        = fips_q;
   assign err_o         = err_q;
   assign edn_o.edn_req = (state_q == StFill);
   assign state_o       = state_q;

endmodule

// File: tb/tb_caliptra_prim_edn_req_arb.sv
// Directed bench for caliptra_prim_edn_req_arb (NumCh=2, OutWidth=128, RepCheck=1, TimeoutCycles=8).
// With CALIPTRA_EDN_REQ_ARB_PREFETCH_EN defined only the prefetch scenario runs.
module tb_caliptra_prim_edn_req_arb;
   import caliptra_prim_edn_req_arb_pkg::*;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic [1:0]   req_i;
   logic [1:0]   ack_o;
   logic [127:0] data_o;
   logic         fips_o, err_o, timeout_o;
   edn_req_t     edn_o;
   edn_rsp_t     edn_i;
   arb_state_e   state_o;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           n_hs     = 0;
   int           n_ack    = 0;
   logic [129:0] exp_q[$];   // {err, fips, data}

   caliptra_prim_edn_req_arb #(
      .NumCh(2), .OutWidth(128), .RepCheck(1'b1), .TimeoutCycles(8)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .ack_o(ack_o), .data_o(data_o),
      .fips_o(fips_o), .err_o(err_o), .timeout_o(timeout_o), .edn_o(edn_o), .edn_i(edn_i),
      .state_o(state_o)
   );

   // Clock and reset
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [129:0] got, input logic [129:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitors: handshake counts and protocol rules on ack_o
   always @(posedge clk_i) begin
      if (rst_ni) begin
         if (edn_o.edn_req && edn_i.edn_ack) n_hs++;
         if (|ack_o) n_ack++;
      end
   end

   always @(negedge clk_i) begin
      if (rst_ni && |ack_o) begin
         check_eq("ack_to_idle_ch", ack_o & ~req_i, 0);
         check_eq("ack_onehot", $onehot(ack_o), 1);
      end
   end

   // Drivers (called at a negedge, return at a negedge)
   task automatic edn_word(input logic [31:0] w, input logic f);
      int n = 0;
      while (!edn_o.edn_req && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("edn_req_wait", edn_o.edn_req, 1);
      edn_i = '{edn_ack: 1'b1, edn_fips: f, edn_bus: w};
      @(negedge clk_i);
      edn_i = '0;
   endtask

   task automatic run_fill(input logic [127:0] d, input logic [3:0] f);
      for (int i = 0; i < 4; i++) edn_word(d[32*i +: 32], f[i]);
   endtask

   task automatic expect_delivery(input string tag, input logic [1:0] ch);
      logic [129:0] e;
      e = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      check_eq({tag, "_ack"}, ack_o, ch);
      check_eq({tag, "_data"}, data_o, e[127:0]);
      check_eq({tag, "_fips"}, fips_o, e[128]);
      check_eq({tag, "_err"}, err_o, e[129]);
      @(negedge clk_i);
      check_eq({tag, "_pulse"}, ack_o, 0);
   endtask

   // Stimulus
   initial begin
      logic [127:0] d;
      int first_k, pulses;
      rst_ni = 1'b0;
      req_i  = '0;
      edn_i  = '0;
      repeat (3) @(negedge clk_i);
      check_eq("rst_ack", ack_o, 0);
      check_eq("rst_data", data_o, 0);
      check_eq("rst_fips", fips_o, 1);
      check_eq("rst_err", err_o, 0);
      check_eq("rst_timeout", timeout_o, 0);
      check_eq("rst_edn_req", edn_o.edn_req, 0);
      check_eq("rst_state", state_o, StIdle);
      rst_ni = 1'b1;
      @(negedge clk_i);

`ifdef CALIPTRA_EDN_REQ_ARB_PREFETCH_EN
      // Idle prefetch, then a request served from the buffer
      d = 128'h00000064_00000063_00000062_00000061;
      run_fill(d, 4'hF);
      exp_q.push_back({1'b0, 1'b1, d});
      check_eq("t6_idle_edn_req", edn_o.edn_req, 0);
      check_eq("t6_idle_ack", ack_o, 0);
      req_i = 2'b10;
      @(negedge clk_i);
      expect_delivery("t6", 2'b10);
      check_eq("t6_refill", edn_o.edn_req, 1);
      req_i = 2'b00;
      @(negedge clk_i);
`else
      // Test 1: single request on ch0
      req_i = 2'b01;
      d = 128'h00000044_00000033_00000022_00000011;
      run_fill(d, 4'hF);
      exp_q.push_back({1'b0, 1'b1, d});
      expect_delivery("t1", 2'b01);
      req_i = 2'b00;

      // Test 3: fips dropped on word 3, then clean
      @(negedge clk_i);
      req_i = 2'b10;
      d = 128'h00000088_00000077_00000066_00000055;
      run_fill(d, 4'b0111);
      exp_q.push_back({1'b0, 1'b0, d});
      expect_delivery("t3_fips0", 2'b10);
      d = 128'h000000CC_000000BB_000000AA_00000099;
      run_fill(d, 4'hF);
      exp_q.push_back({1'b0, 1'b1, d});
      expect_delivery("t3_fips1", 2'b10);
      req_i = 2'b00;

      // Test 4: repeated word sets err, next output clean
      @(negedge clk_i);
      req_i = 2'b01;
      d = 128'h00000002_00000001_A5A5A5A5_A5A5A5A5;
      run_fill(d, 4'hF);
      exp_q.push_back({1'b1, 1'b1, d});
      expect_delivery("t4_rep", 2'b01);
      req_i = 2'b10;
      d = 128'h00000006_00000005_00000004_00000003;
      run_fill(d, 4'hF);
      exp_q.push_back({1'b0, 1'b1, d});
      expect_delivery("t4_norep", 2'b10);
      req_i = 2'b00;

      // Test 2: both channels held, last grant was ch1 -> ch0, ch1, ch0
      @(negedge clk_i);
      req_i = 2'b11;
      for (int k = 0; k < 3; k++) begin
         d = {32'h2000 + 32'(4*k + 4), 32'h2000 + 32'(4*k + 3),
              32'h2000 + 32'(4*k + 2), 32'h2000 + 32'(4*k + 1)};
         run_fill(d, 4'hF);
         exp_q.push_back({1'b0, 1'b1, d});
         expect_delivery("t2_rr", (k == 1) ? 2'b10 : 2'b01);
      end
      req_i = 2'b00;
      check_eq("t2_edn_per_ack", n_hs, 4 * n_ack);

      // Granted channel drops req mid-fill: fill completes, no ack, data_o unchanged
      @(negedge clk_i);
      req_i = 2'b01;
      edn_word(32'hDEAD0001, 1'b1);
      edn_word(32'hDEAD0002, 1'b1);
      req_i = 2'b00;
      edn_word(32'hDEAD0003, 1'b1);
      edn_word(32'hDEAD0004, 1'b1);
      check_eq("drop_ack", ack_o, 0);
      check_eq("drop_state", state_o, StIdle);
      check_eq("drop_data", data_o, {32'h200C, 32'h200B, 32'h200A, 32'h2009});
      @(negedge clk_i);
      check_eq("drop_ack_later", ack_o, 0);

      // Test 5: EDN stall timeout, then reset mid-fill
      req_i = 2'b01;
      begin
         int n = 0;
         while (!edn_o.edn_req && n < 20) begin
            @(negedge clk_i);
            n++;
         end
      end
      first_k = 0;
      pulses  = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk_i);
         if (timeout_o) begin
            pulses++;
            if (first_k == 0) first_k = k;
         end
      end
      check_eq("t5_timeout_cycle", first_k, 8);
      check_eq("t5_timeout_pulses", pulses, 1);
      check_eq("t5_fill_continues", edn_o.edn_req, 1);
      #3 rst_ni = 1'b0;
      #1;
      check_eq("t5_rst_edn_req", edn_o.edn_req, 0);
      check_eq("t5_rst_state", state_o, StIdle);
      check_eq("t5_rst_fips", fips_o, 1);
      check_eq("t5_rst_data", data_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      // First word repeats the last pre-reset word: rep check must be disarmed
      d = 128'h0000E003_0000E002_0000E001_DEAD0004;
      edn_word(d[31:0], 1'b1);
      edn_word(d[63:32], 1'b1);
      check_eq("t5_no_early_ack", ack_o, 0);
      edn_word(d[95:64], 1'b1);
      check_eq("t5_no_early_ack2", ack_o, 0);
      edn_word(d[127:96], 1'b1);
      exp_q.push_back({1'b0, 1'b1, d});
      expect_delivery("t5_after_rst", 2'b01);
      req_i = 2'b00;
      @(negedge clk_i);
`endif

      check_eq("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
